// File: rtl/aud_dac_stream_ctrl_if.sv
// Frame source handshake between the sample-source logic and the DAC
// stream controller: one stereo PCM frame per accepted valid/ready beat.
`timescale 1ns/1ps
interface aud_dac_stream_ctrl_if #(
  parameter int SAMPLE_W = 16
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;

  // Sample source side: offers frames.
  modport master (
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready
  );

  // Stream controller side: accepts frames into its FIFO.
  modport slave (
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready
  );
endinterface

// File: rtl/aud_dac_stream_ctrl.sv
// Audio DAC stream controller.
// Buffers stereo PCM frames in a small FIFO and serialises them to the
// codec DAC input in I2S format. The codec is bit-clock master, so BCLK and
// LRCK are sampled into the system clock domain and turned into edge
// strobes; all state runs on clkin_50.
`timescale 1ns/1ps
module aud_dac_stream_ctrl #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic                  clkin_50,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_flush,
  aud_dac_stream_ctrl_if.slave  s_if,
  input  logic                  aud_bclk,
  input  logic                  aud_dac_lrck,
  output logic                  aud_dac_dat,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  frame_tick,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  // Codec clock synchronisers and edge detection
  logic bclk_meta_r;
  logic bclk_sync_r;
  logic bclk_dly_r;
  logic lrck_meta_r;
  logic lrck_sync_r;
  logic lrck_hold_r;
  logic primed_r;

  // FIFO storage and bookkeeping
  logic [SAMPLE_W-1:0] mem_left_r  [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_right_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic                ready_r;

  // Serialiser state
  logic [SAMPLE_W-1:0] frame_right_r;
  logic [SAMPLE_W-1:0] shift_r;
  logic [CNT_W-1:0]    bits_left_r;

  // Combinational decode
  logic                rise_e_s;
  logic                fall_e_s;
  logic                boundary_s;
  logic                left_bnd_s;
  logic                right_bnd_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic                under_set_s;
  logic [LVL_W-1:0]    level_nxt_s;
  logic                ready_nxt_s;
  logic [SAMPLE_W-1:0] pop_left_s;
  logic [SAMPLE_W-1:0] pop_right_s;

  assign s_if.s_ready = ready_r;

  // Decode codec clock events, slot boundaries and FIFO push/pop for this cycle.
  always_comb begin
    rise_e_s    = bclk_sync_r & ~bclk_dly_r;
    fall_e_s    = ~bclk_sync_r & bclk_dly_r;
    boundary_s  = rise_e_s & primed_r & (lrck_sync_r != lrck_hold_r);
    left_bnd_s  = boundary_s & ~lrck_sync_r;
    right_bnd_s = boundary_s & lrck_sync_r;
    // A flush in the same cycle makes the pop side see an empty FIFO.
    empty_s     = (fifo_level == {LVL_W{1'b0}}) | fifo_flush;
    push_s      = s_if.s_valid & ready_r & ~fifo_flush;
    pop_s       = left_bnd_s & enable & ~empty_s;
    under_set_s = left_bnd_s & enable & empty_s;
    pop_left_s  = mem_left_r[rd_ptr_r];
    pop_right_s = mem_right_r[rd_ptr_r];

    if (fifo_flush) begin
      level_nxt_s = {LVL_W{1'b0}};
    end else if (push_s && !pop_s) begin
      level_nxt_s = fifo_level + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = fifo_level - LVL_W'(1);
    end else begin
      level_nxt_s = fifo_level;
    end

    ready_nxt_s = (level_nxt_s != LVL_W'(FIFO_DEPTH));
  end

  // Two-flop synchronisers for BCLK/LRCK plus a delay stage for BCLK edge strobes.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      bclk_meta_r <= 1'b0;
      bclk_sync_r <= 1'b0;
      bclk_dly_r  <= 1'b0;
      lrck_meta_r <= 1'b0;
      lrck_sync_r <= 1'b0;
    end else begin
      bclk_meta_r <= aud_bclk;
      bclk_sync_r <= bclk_meta_r;
      bclk_dly_r  <= bclk_sync_r;
      lrck_meta_r <= aud_dac_lrck;
      lrck_sync_r <= lrck_meta_r;
    end
  end

  // Track the LRCK level seen at BCLK rises; the first rise after reset only
  // primes the tracker so a stale reset value cannot fake a channel boundary.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      primed_r    <= 1'b0;
      lrck_hold_r <= 1'b0;
    end else if (rise_e_s) begin
      if (!primed_r) begin
        primed_r    <= 1'b1;
        lrck_hold_r <= lrck_sync_r;
      end else if (lrck_sync_r != lrck_hold_r) begin
        primed_r    <= 1'b1;
        lrck_hold_r <= lrck_sync_r;
      end else begin
        primed_r    <= primed_r;
        lrck_hold_r <= lrck_hold_r;
      end
    end else begin
      primed_r    <= primed_r;
      lrck_hold_r <= lrck_hold_r;
    end
  end

  // Frame FIFO: write on accepted beats, read at playing left boundaries,
  // flush resets pointers and level without touching the serialiser.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_left_r[i]  <= {SAMPLE_W{1'b0}};
        mem_right_r[i] <= {SAMPLE_W{1'b0}};
      end
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_level <= {LVL_W{1'b0}};
      ready_r    <= 1'b1;
    end else begin
      if (push_s) begin
        mem_left_r[wr_ptr_r]  <= s_if.s_left;
        mem_right_r[wr_ptr_r] <= s_if.s_right;
      end else begin
        mem_left_r[wr_ptr_r]  <= mem_left_r[wr_ptr_r];
        mem_right_r[wr_ptr_r] <= mem_right_r[wr_ptr_r];
      end

      if (fifo_flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        wr_ptr_r <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
        rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
      end

      fifo_level <= level_nxt_s;
      ready_r    <= ready_nxt_s;
    end
  end

  // Load slot words at channel boundaries and shift them out MSB-first on
  // BCLK falls; once a word is exhausted the rest of the slot is padded with 0.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      frame_right_r <= {SAMPLE_W{1'b0}};
      shift_r       <= {SAMPLE_W{1'b0}};
      bits_left_r   <= {CNT_W{1'b0}};
      aud_dac_dat   <= 1'b0;
    end else if (left_bnd_s) begin
      frame_right_r <= pop_s ? pop_right_s : {SAMPLE_W{1'b0}};
      shift_r       <= pop_s ? pop_left_s  : {SAMPLE_W{1'b0}};
      bits_left_r   <= CNT_W'(SAMPLE_W);
      aud_dac_dat   <= aud_dac_dat;
    end else if (right_bnd_s) begin
      frame_right_r <= frame_right_r;
      shift_r       <= frame_right_r;
      bits_left_r   <= CNT_W'(SAMPLE_W);
      aud_dac_dat   <= aud_dac_dat;
    end else if (fall_e_s) begin
      frame_right_r <= frame_right_r;
      if (bits_left_r != {CNT_W{1'b0}}) begin
        aud_dac_dat <= shift_r[SAMPLE_W-1];
        shift_r     <= {shift_r[SAMPLE_W-2:0], 1'b0};
        bits_left_r <= bits_left_r - CNT_W'(1);
      end else begin
        aud_dac_dat <= 1'b0;
        shift_r     <= shift_r;
        bits_left_r <= bits_left_r;
      end
    end else begin
      frame_right_r <= frame_right_r;
      shift_r       <= shift_r;
      bits_left_r   <= bits_left_r;
      aud_dac_dat   <= aud_dac_dat;
    end
  end

  // Status: one-cycle pop strobe and a sticky underrun flag whose set wins over clear.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_tick <= pop_s;
      if (under_set_s) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end else begin
        underrun <= underrun;
      end
    end
  end

endmodule

// File: tb/tb_aud_dac_stream_ctrl.sv
// Directed bench for aud_dac_stream_ctrl: a codec model drives BCLK/LRCK
// (64 BCLK per frame) and deserialises the I2S stream back into frames.
`timescale 1ns/1ps
module tb_aud_dac_stream_ctrl;

  logic        clkin_50     = 1'b0;
  logic        rst_n        = 1'b0;
  logic        enable       = 1'b0;
  logic        fifo_flush   = 1'b0;
  logic        aud_bclk     = 1'b0;
  logic        aud_dac_lrck = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        aud_dac_dat;
  logic [3:0]  fifo_level;
  logic        frame_tick;
  logic        underrun;

  aud_dac_stream_ctrl_if #(.SAMPLE_W(16)) s_if ();

  aud_dac_stream_ctrl #(
    .SAMPLE_W(16), .FIFO_DEPTH(8), .LVL_W(4)
  ) dut (
    .clkin_50(clkin_50), .rst_n(rst_n), .enable(enable), .fifo_flush(fifo_flush),
    .s_if(s_if), .aud_bclk(aud_bclk), .aud_dac_lrck(aud_dac_lrck),
    .aud_dac_dat(aud_dac_dat), .fifo_level(fifo_level), .frame_tick(frame_tick),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [3:0]  exp_level;
    logic        exp_ready;
  } vec_t;

  vec_t tbl [8];

  int checks = 0;
  int errors = 0;

  // Codec model state
  int          idx = 0;
  int          rx_n = 0;
  int          pad_ones = 0;
  int          tick_cnt = 0;
  int          prio_cnt = 0;
  logic [15:0] rx_l = 16'h0000;
  logic [15:0] rx_r = 16'h0000;
  logic [15:0] got_l = 16'h0000;
  logic [15:0] got_r = 16'h0000;

  always #10 clkin_50 = ~clkin_50;

  // Codec clocks: BCLK period 320 ns, LRCK low for bits 0..31 (left), high for 32..63.
  initial begin
    #5;
    forever begin
      #160 aud_bclk = 1'b1;
      #160 aud_bclk = 1'b0;
      idx = (idx + 1) % 64;
      aud_dac_lrck = (idx >= 32);
    end
  end

  // Codec receiver: I2S data bits sit on rises 1..16 (left) and 33..48 (right).
  always @(posedge aud_bclk) begin
    if (idx >= 1 && idx <= 16) begin
      rx_l = {rx_l[14:0], aud_dac_dat};
    end else if (idx >= 33 && idx <= 48) begin
      rx_r = {rx_r[14:0], aud_dac_dat};
      if (idx == 48) begin
        got_l = rx_l;
        got_r = rx_r;
        rx_n++;
      end
    end else if (aud_dac_dat) begin
      pad_ones++;
    end
  end

  // Event counters sampled mid-cycle.
  always @(negedge clkin_50) begin
    if (frame_tick) tick_cnt++;
    if (underrun_clr && underrun) prio_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    @(negedge clkin_50);
    s_if.s_valid = 1'b1;
    s_if.s_left  = l;
    s_if.s_right = r;
    @(negedge clkin_50);
    s_if.s_valid = 1'b0;
  endtask

  task automatic sync_to_idx(input int k);
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clkin_50);
      if (idx == k) done = 1'b1;
    end
    if (!done) chk("sync_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rx();
    int start = rx_n;
    bit done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clkin_50);
      if (rx_n != start) done = 1'b1;
    end
    if (!done) chk("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_left_rise();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge aud_bclk);
      if (idx == 0) done = 1'b1;
    end
    if (!done) chk("left_rise_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clkin_50);
    underrun_clr = 1'b1;
    @(negedge clkin_50);
    underrun_clr = 1'b0;
  endtask

  initial begin
    int t0;
    int p0;
    s_if.s_valid = 1'b0;
    s_if.s_left  = 16'h0000;
    s_if.s_right = 16'h0000;

    tbl[0] = '{16'h0001, 16'hFFFE, 4'd1, 1'b1};
    tbl[1] = '{16'h1234, 16'h5678, 4'd2, 1'b1};
    tbl[2] = '{16'h8000, 16'h7FFF, 4'd3, 1'b1};
    tbl[3] = '{16'hDEAD, 16'hBEEF, 4'd4, 1'b1};
    tbl[4] = '{16'h00FF, 16'hFF00, 4'd5, 1'b1};
    tbl[5] = '{16'hAAAA, 16'h5555, 4'd6, 1'b1};
    tbl[6] = '{16'hC001, 16'h0C30, 4'd7, 1'b1};
    tbl[7] = '{16'h7E81, 16'h9669, 4'd8, 1'b0};

    // Reset values
    #25;
    chk("rst_dat", {31'd0, aud_dac_dat}, 32'd0);
    chk("rst_ready", {31'd0, s_if.s_ready}, 32'd1);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    @(negedge clkin_50);
    @(negedge clkin_50);
    rst_n = 1'b1;

    // T1: one prefilled frame plays as A5C3 / 0F0F
    push(16'hA5C3, 16'h0F0F);
    chk("t1_level", {28'd0, fifo_level}, 32'd1);
    sync_to_idx(50);
    t0 = tick_cnt;
    enable = 1'b1;
    wait_rx();
    enable = 1'b0;
    chk("t1_left", {16'd0, got_l}, 32'h0000A5C3);
    chk("t1_right", {16'd0, got_r}, 32'h00000F0F);
    chk("t1_ticks", tick_cnt - t0, 32'd1);
    chk("t1_underrun", {31'd0, underrun}, 32'd0);

    // T2: fill to full, then play all eight across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].l, tbl[i].r);
      chk($sformatf("t2_level_%0d", i), {28'd0, fifo_level}, {28'd0, tbl[i].exp_level});
      chk($sformatf("t2_ready_%0d", i), {31'd0, s_if.s_ready}, {31'd0, tbl[i].exp_ready});
    end
    push(16'h9999, 16'h9999);
    chk("t2_full_level", {28'd0, fifo_level}, 32'd8);
    chk("t2_full_ready", {31'd0, s_if.s_ready}, 32'd0);
    sync_to_idx(50);
    t0 = tick_cnt;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_rx();
      chk($sformatf("t2_left_%0d", i), {16'd0, got_l}, {16'd0, tbl[i].l});
      chk($sformatf("t2_right_%0d", i), {16'd0, got_r}, {16'd0, tbl[i].r});
    end
    enable = 1'b0;
    chk("t2_ticks", tick_cnt - t0, 32'd8);
    chk("t2_level_end", {28'd0, fifo_level}, 32'd0);
    chk("t2_underrun", {31'd0, underrun}, 32'd0);

    // T3: empty FIFO at a playing left boundary -> silence and underrun
    sync_to_idx(50);
    enable = 1'b1;
    wait_rx();
    enable = 1'b0;
    chk("t3_left", {16'd0, got_l}, 32'd0);
    chk("t3_right", {16'd0, got_r}, 32'd0);
    chk("t3_underrun", {31'd0, underrun}, 32'd1);
    pulse_clr();
    chk("t3_cleared", {31'd0, underrun}, 32'd0);
    // Clear held across a new underrun: the set must still show up
    p0 = prio_cnt;
    sync_to_idx(50);
    enable = 1'b1;
    sync_to_idx(60);
    underrun_clr = 1'b1;
    sync_to_idx(3);
    underrun_clr = 1'b0;
    enable = 1'b0;
    chk("t3_set_beats_clr", {31'd0, (prio_cnt != p0)}, 32'd1);

    // T4: flush while the first of three frames is shifting
    pulse_clr();
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    push(16'h5555, 16'h6666);
    chk("t4_level", {28'd0, fifo_level}, 32'd3);
    sync_to_idx(50);
    t0 = tick_cnt;
    enable = 1'b1;
    sync_to_idx(5);
    @(negedge clkin_50);
    fifo_flush = 1'b1;
    @(negedge clkin_50);
    fifo_flush = 1'b0;
    chk("t4_flush_level", {28'd0, fifo_level}, 32'd0);
    wait_rx();
    chk("t4_left", {16'd0, got_l}, 32'h00001111);
    chk("t4_right", {16'd0, got_r}, 32'h00002222);
    wait_rx();
    enable = 1'b0;
    chk("t4_silent", {got_l, got_r}, 32'd0);
    chk("t4_underrun", {31'd0, underrun}, 32'd1);
    chk("t4_ticks", tick_cnt - t0, 32'd1);
    pulse_clr();

    // T5: reset in the middle of a right slot
    push(16'h1234, 16'hFFFF);
    sync_to_idx(50);
    enable = 1'b1;
    sync_to_idx(40);
    chk("t5_dat_before", {31'd0, aud_dac_dat}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_dat_in_reset", {31'd0, aud_dac_dat}, 32'd0);
    chk("t5_level_in_reset", {28'd0, fifo_level}, 32'd0);
    @(negedge clkin_50);
    @(negedge clkin_50);
    rst_n = 1'b1;
    t0 = tick_cnt;
    push(16'h8001, 16'h7FFE);
    sync_to_idx(63);
    chk("t5_no_early_tick", tick_cnt - t0, 32'd0);
    chk("t5_no_underrun", {31'd0, underrun}, 32'd0);
    wait_rx();
    enable = 1'b0;
    chk("t5_left", {16'd0, got_l}, 32'h00008001);
    chk("t5_right", {16'd0, got_r}, 32'h00007FFE);
    chk("t5_ticks", tick_cnt - t0, 32'd1);

    // T6: push lands in the same cycle as the pop at level 1
    push(16'hCAFE, 16'hBEEF);
    sync_to_idx(50);
    t0 = tick_cnt;
    enable = 1'b1;
    wait_left_rise();
    @(negedge clkin_50);
    @(negedge clkin_50);
    chk("t6_level_before", {28'd0, fifo_level}, 32'd1);
    s_if.s_valid = 1'b1;
    s_if.s_left  = 16'hDEAD;
    s_if.s_right = 16'h0001;
    @(negedge clkin_50);
    s_if.s_valid = 1'b0;
    chk("t6_level_same", {28'd0, fifo_level}, 32'd1);
    chk("t6_tick_same", {31'd0, frame_tick}, 32'd1);
    wait_rx();
    enable = 1'b0;
    chk("t6_left", {16'd0, got_l}, 32'h0000CAFE);
    chk("t6_right", {16'd0, got_r}, 32'h0000BEEF);
    chk("t6_underrun", {31'd0, underrun}, 32'd0);
    chk("t6_level_end", {28'd0, fifo_level}, 32'd1);
    chk("t6_ticks", tick_cnt - t0, 32'd1);

    // Padding bits outside the 16-bit data windows must always be 0
    chk("pad_zero", pad_ones, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
